ir_operand_latch: RTL
=====================

// Module: ir_operand_latch
// PURPOSE
//   Parametrised successor to the 6502 instruction register. Captures the opcode on the
//   sync (opcode-fetch) cycle, then captures up to MAX_OPS operand bytes under an ld strobe.
//   Presents the assembled operand word, little-endian, to the decode/ALU stage.
//   Can substitute a forced opcode for interrupt entry (force_brk).
// PARAMETERS
//   DATA_W     8      bus / opcode width in bits
//   MAX_OPS    2      maximum operand bytes per instruction
//   BRK_OPCODE 8'h00  opcode substituted when force_brk is high on sync
//   OPL_W      local = $clog2(MAX_OPS+2); width of op_len/op_idx (can encode MAX_OPS+1)
// PORTS
//   clk        in   1              system clock; all state changes on posedge
//   rst_n      in   1              reset, synchronous, active-low
//   data       in   DATA_W         data bus: opcode on sync, operand byte on ld
//   sync       in   1              opcode-fetch cycle strobe
//   force_brk  in   1              with sync: load BRK_OPCODE instead of data
//   ld         in   1              operand byte valid on data
//   op_len     in   OPL_W          operand byte count from decoder, sampled in DECODE
//   ir         out  DATA_W         current opcode
//   operand    out  DATA_W*MAX_OPS operand bytes; byte i in [i*DATA_W +: DATA_W]
//   op_idx     out  OPL_W          operand bytes captured so far
//   ready      out  1              all required operand bytes captured
//   forced     out  1              current ir was injected via force_brk
//   err        out  1              op_len > MAX_OPS seen; sticky until next sync
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): ir=0, operand=0, op_idx=0, ready=0, forced=0, err=0,
//     state=IDLE. Reset overrides sync/ld in the same cycle and is legal in any state.
//   States: IDLE, DECODE, FETCH, READY. All outputs are registered.
//   sync=1 (any state, highest priority after reset):
//     - ir <= force_brk ? BRK_OPCODE : data; forced <= force_brk.
//     - operand <= 0, op_idx <= 0, ready <= 0, err <= 0; state <= DECODE.
//     - ld is ignored in the same cycle.
//     - ir is visible the cycle after the sync edge (1-cycle latency).
//   DECODE (exactly 1 cycle): sample op_len into internal target tgt. ld is ignored.
//     - op_len == 0: ready <= 1; -> READY.
//     - 1 <= op_len <= MAX_OPS: tgt <= op_len; -> FETCH.
//     - op_len > MAX_OPS: err <= 1; tgt <= MAX_OPS (clamp); -> FETCH.
//   FETCH: on ld, operand[op_idx*DATA_W +: DATA_W] <= data; op_idx <= op_idx+1.
//     - When op_idx+1 == tgt: ready <= 1; -> READY.
//     - Without ld, state holds; no timeout.
//   READY: ready stays 1; ld is ignored (operand not modified); exit only via sync or reset.
//   IDLE: wait for sync; ld is ignored. IDLE is entered only from reset.
//   A sync arriving mid-FETCH abandons the partial operand; there is no error for this case.
//   forced does not alter operand fetch; op_len still comes from the decoder.
//   op_idx never exceeds MAX_OPS; the index does not wrap.
// TESTING
//   1 rst_n=0 2 cycles with sync=1, data=8'h5A -> ir=00, ready=0, op_idx=0, all outputs 0.
//   2 sync data=A9; op_len=1; ld data=42 -> ir=A9, operand=16'h0042, op_idx=1,
//     ready=1 the cycle after ld; a further ld with 99 leaves operand unchanged.
//   3 sync data=4C; op_len=2; ld 34 with gap cycles; then ld 12 -> operand=16'h1234,
//     op_idx=2, ready rises only after the 2nd ld.
//   4 sync=1, force_brk=1, data=A5; op_len=0 -> ir=00, forced=1, ready=1 two cycles
//     after sync; the next normal sync clears forced.
//   5 sync data=20; op_len=3 (>MAX_OPS) -> err=1; ready after 2 ld; the next sync clears err.
//   6 mid-FETCH after 1 ld: sync data=EA -> ir=EA, operand=0, op_idx=0.
//     Separately, rst_n=0 mid-FETCH -> all outputs 0, state=IDLE.

Source files
------------

// File: rtl/ir_operand_latch.sv
// ir_operand_latch: opcode register plus little-endian operand byte latch for the decode/ALU stage
// Ports:
//   clk_i        system clock, all state changes on posedge
//   rst_n_i      synchronous active-low reset
//   data_i       opcode on sync_i, operand byte on ld_i
//   sync_i       opcode-fetch strobe, restarts the instruction from any state
//   force_brk_i  with sync_i, load BRK_OPCODE instead of data_i
//   ld_i         operand byte valid on data_i
//   op_len_i     operand byte count from the decoder, sampled one cycle after sync_i
//   ir_o         current opcode
//   operand_o    operand bytes, byte i at [i*DATA_W +: DATA_W]
//   op_idx_o     operand bytes captured so far
//   ready_o      all required operand bytes captured
//   forced_o     current opcode was injected through force_brk_i
//   err_o        decoder asked for more than MAX_OPS bytes, sticky until next sync_i
module ir_operand_latch #(
  parameter int                 DATA_W     = 8,
  parameter int                 MAX_OPS    = 2,
  parameter logic [DATA_W-1:0]  BRK_OPCODE = '0,
  localparam int                OPL_W      = $clog2(MAX_OPS + 2)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        sync_i,
  input  logic                        force_brk_i,
  input  logic                        ld_i,
  input  logic [OPL_W-1:0]            op_len_i,
  output logic [DATA_W-1:0]           ir_o,
  output logic [DATA_W*MAX_OPS-1:0]   operand_o,
  output logic [OPL_W-1:0]            op_idx_o,
  output logic                        ready_o,
  output logic                        forced_o,
  output logic                        err_o
);
  typedef enum logic [1:0] {IDLE, DECODE, FETCH, READY} state_t;
  localparam logic [OPL_W-1:0] MAX_L = OPL_W'(MAX_OPS);
  state_t                      state_q;
  logic [OPL_W-1:0]            tgt_q;
  logic [DATA_W-1:0]           ir_q;
  logic [DATA_W*MAX_OPS-1:0]   operand_q;
  logic [OPL_W-1:0]            op_idx_q;
  logic                        ready_q;
  logic                        forced_q;
  logic                        err_q;
  logic [OPL_W-1:0]            op_idx_d;
  assign op_idx_d = op_idx_q + OPL_W'(1);
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      ir_q      <= '0;
      operand_q <= '0;
      op_idx_q  <= '0;
      ready_q   <= 1'b0;
      forced_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (sync_i) begin
      state_q   <= DECODE;
      ir_q      <= force_brk_i ? BRK_OPCODE : data_i;
      forced_q  <= force_brk_i;
      operand_q <= '0;
      op_idx_q  <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        DECODE: begin
          // oversize requests are clamped so op_idx can never pass MAX_OPS
          tgt_q   <= (op_len_i > MAX_L) ? MAX_L : op_len_i;
          err_q   <= op_len_i > MAX_L;
          ready_q <= op_len_i == '0;
          state_q <= (op_len_i == '0) ? READY : FETCH;
        end
        FETCH: if (ld_i) begin
          for (int i = 0; i < MAX_OPS; i++)
            if (op_idx_q == OPL_W'(i)) operand_q[i*DATA_W +: DATA_W] <= data_i;
          op_idx_q <= op_idx_d;
          if (op_idx_d == tgt_q) begin
            ready_q <= 1'b1;
            state_q <= READY;
          end
        end
        default: ;
      endcase
    end
  end
  assign ir_o      = ir_q;
  assign operand_o = operand_q;
  assign op_idx_o  = op_idx_q;
  assign ready_o   = ready_q;
  assign forced_o  = forced_q;
  assign err_o     = err_q;
endmodule
